pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Stage sequencer and hazard controller for the five-stage pipeline. It drives the per-stage enable and bubble (`stg_x`) inputs of the IF/ID, ID/EX, EX/MEM (ALU latch) and MEM/WB latches. It also generates the ALU operand forwarding selects from the `rd`/`save_to_reg` fields held in those latches. It resolves load-use hazards, taken-branch flushes and multi-cycle EX operations, and counts stall cycles for debug.

## Interface
Parameters:
- `MC_MAX_CYCLES`, default 32: watchdog limit, in cycles, for a multi-cycle EX operation.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `stg_clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the instruction in ID reads rs1 / rs2.
- `ex_rs1`, `ex_rs2`  in  5 each  source registers held in the ID/EX latch.
- `ex_rd`  in  5  destination register held in the ID/EX latch.
- `ex_save_to_reg`, `ex_is_load`  in  1 each  ID/EX write-back flag and load flag.
- `mem_rd`  in  5  `rd_out` of the ALU (EX/MEM) latch.
- `mem_save_to_reg`  in  1  `save_to_reg_out` of the ALU latch.
- `wb_rd`  in  5  destination register held in the MEM/WB latch.
- `wb_save_to_reg`  in  1  MEM/WB write-back flag.
- `branch_taken`  in  1  taken branch resolved in EX this cycle.
- `mc_start`  in  1  a multi-cycle operation in EX begins this cycle.
- `mc_done`  in  1  the multi-cycle unit's result is valid this cycle.
- `ena_if`, `ena_id`, `ena_ex`, `ena_mem`, `ena_wb`  out  1 each  latch enables.
- `x_id`, `x_ex`, `x_mem`  out  1 each  bubble inserts: the latch loads a NOP and clears `save_to_reg`.
- `fwd_a`, `fwd_b`  out  2 each  ALU operand select: 00 = register file, 01 = ALU latch `c_out`, 10 = WB value.
- `stall_cnt`  out  `CNT_W`  saturating count of stalled cycles.
- `mc_timeout`  out  1  sticky flag, set when the watchdog fires.
- `busy`  out  1  the FSM is not in RUN.

## Operation
States: RUN, MC_WAIT, MC_DRAIN. Hazard, flush and forwarding terms below are combinational from the current state and inputs.

Forwarding (fwd_a shown; fwd_b is identical using `ex_rs2`):
- 01 if `mem_save_to_reg`, `mem_rd`≠0 and `mem_rd`==`ex_rs1`.
- Otherwise 10 if `wb_save_to_reg`, `wb_rd`≠0 and `wb_rd`==`ex_rs1`.
- Otherwise 00.
- MEM always takes priority over WB.

Load-use hazard: `lu = ex_is_load & ex_save_to_reg & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`.

RUN, in priority order:
1. `branch_taken`: all enables 1; `x_id`=1 and `x_ex`=1 for exactly one cycle. This suppresses a coincident `lu` and `mc_start`. Stay in RUN.
2. `mc_start`: `ena_if`/`ena_id`/`ena_ex`=0, `ena_mem`/`ena_wb`=1, `x_mem`=1. Next state MC_WAIT; watchdog counter cleared.
3. `lu`: `ena_if`/`ena_id`=0, `ena_ex`/`ena_mem`/`ena_wb`=1, `x_ex`=1. Exactly one stall cycle.
4. Otherwise: all enables 1, all x 0.

MC_WAIT:
- Outputs are the same as for `mc_start`. The watchdog counter increments each cycle.
- `mc_done`: next state MC_DRAIN.
- Else if the counter reaches `MC_MAX_CYCLES`-1: set `mc_timeout`; next state RUN.

MC_DRAIN:
- One cycle with all enables 1 and x 0, so the result is latched into EX/MEM. Next state RUN.
- `branch_taken` and `lu` are evaluated again from RUN on the following cycle.

`stall_cnt` increments on every cycle with `ena_if`=0 and saturates at all-ones. `busy` = (state≠RUN).

## Timing
- Reset (`reset`=0, asynchronous):
  - state RUN, watchdog counter 0, `stall_cnt`=0, `mc_timeout`=0.
  - While reset is held, all `ena_*`=0 and all `x_*`=0.
  - The first cycle after release behaves as RUN.
- Reset asserted mid-MC_WAIT aborts the operation immediately, with no drain cycle.
- Enables, bubbles and forwarding selects are Mealy outputs, valid before the same `stg_clk` edge that the latches sample. There is zero added latency.
- A load-use stall costs 1 cycle. A taken-branch flush costs 2 squashed instructions.
- A multi-cycle operation costs N+1 cycles, where N is the number of MC_WAIT cycles.
- `mc_done` in the same cycle as `mc_start` is ignored. Completion is honoured only in MC_WAIT.
- `rd`=0 never forwards and never triggers a stall.

## Structure
- Shared package `pipe_pkg`:
  - FSM state encoding.
  - Forwarding select constants `FWD_RF`, `FWD_ALU`, `FWD_WB`.
  - `REG_ZERO`=5'd0.
- Sub-module `fwd_unit`: purely combinational. Instantiated once and produces both `fwd_a` and `fwd_b`.
- The FSM, watchdog and stall counter live in the top level.

## Test plan
- Forwarding priority:
  - `mem_rd`=5, `wb_rd`=5, both save flags 1, `ex_rs1`=5 -> `fwd_a`=01.
  - Clear `mem_save_to_reg` -> `fwd_a`=10.
  - `mem_rd`=0 with `ex_rs2`=0 -> `fwd_b`=00.
- Load-use: `ex_is_load`=1, `ex_rd`=7, `id_rs2`=7, `id_use_rs2`=1 -> one cycle with `ena_if`=`ena_id`=0 and `x_ex`=1, then normal; `stall_cnt`=1.
- Branch over hazard: `branch_taken`=1 with `lu` true -> `x_id`=`x_ex`=1, all enables 1, `stall_cnt` unchanged.
- Multi-cycle: `mc_start` pulse, `mc_done` 4 cycles later -> `busy` high for 5 cycles, `x_mem`=1 for 5 cycles, then one drain cycle; `stall_cnt`=5.
- Watchdog: `MC_MAX_CYCLES`=8, no `mc_done` -> `mc_timeout`=1 after 8 MC_WAIT cycles, returns to RUN, and the flag stays set until reset.
- Async reset: drop `reset` mid-MC_WAIT -> all enables 0 immediately, `busy`=0, counters 0, with no dependence on `stg_clk`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline controller and its forwarding unit.
// Combinational helper only; no state, no backpressure.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MC_WAIT  = 2'd1,
        ST_MC_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_ALU = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // The younger result in the ALU latch always wins over the WB value.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_save,
        input logic [4:0] mem_rd,
        input logic       wb_save,
        input logic [4:0] wb_rd,
        input logic [4:0] rs
    );
        if (mem_save && (mem_rd != REG_ZERO) && (mem_rd == rs))
            return FWD_ALU;
        else if (wb_save && (wb_rd != REG_ZERO) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// ALU operand forwarding selects for both EX source operands.
// Purely combinational, zero latency; no backpressure.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rs1_i,
    input  logic [4:0] ex_rs2_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_save_to_reg_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_save_to_reg_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    assign fwd_a_o = fwd_sel(mem_save_to_reg_i, mem_rd_i, wb_save_to_reg_i, wb_rd_i, ex_rs1_i);
    assign fwd_b_o = fwd_sel(mem_save_to_reg_i, mem_rd_i, wb_save_to_reg_i, wb_rd_i, ex_rs2_i);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage sequencer: latch enables/bubbles, forwarding, load-use, flush and multi-cycle EX control.
// Mealy enables with zero added latency; stalls front stages on load-use and while a multi-cycle op runs.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MC_MAX_CYCLES = 32,
    parameter int CNT_W         = 16
) (
    input  logic             stg_clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_save_to_reg,
    input  logic             ex_is_load,
    input  logic [4:0]       mem_rd,
    input  logic             mem_save_to_reg,
    input  logic [4:0]       wb_rd,
    input  logic             wb_save_to_reg,
    input  logic             branch_taken,
    input  logic             mc_start,
    input  logic             mc_done,
    output logic             ena_if,
    output logic             ena_id,
    output logic             ena_ex,
    output logic             ena_mem,
    output logic             ena_wb,
    output logic             x_id,
    output logic             x_ex,
    output logic             x_mem,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mc_timeout,
    output logic             busy
);

    localparam int             WD_W    = (MC_MAX_CYCLES > 2) ? $clog2(MC_MAX_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_MAX_CYCLES - 1);

    state_t            state_q;
    logic [WD_W-1:0]   wd_q;
    logic [CNT_W-1:0]  stall_q;
    logic              timeout_q;

    logic lu;
    logic in_run;
    logic flush;
    logic mc_hold;
    logic lu_stall;
    logic front_stall;

    fwd_unit u_fwd (
        .ex_rs1_i          (ex_rs1),
        .ex_rs2_i          (ex_rs2),
        .mem_rd_i          (mem_rd),
        .mem_save_to_reg_i (mem_save_to_reg),
        .wb_rd_i           (wb_rd),
        .wb_save_to_reg_i  (wb_save_to_reg),
        .fwd_a_o           (fwd_a),
        .fwd_b_o           (fwd_b)
    );

    assign lu = ex_is_load & ex_save_to_reg & (ex_rd != REG_ZERO)
              & ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Branch flush outranks a multi-cycle start, which outranks a load-use stall.
    assign in_run      = (state_q == ST_RUN);
    assign flush       = in_run & branch_taken;
    assign mc_hold     = (in_run & ~branch_taken & mc_start) | (state_q == ST_MC_WAIT);
    assign lu_stall    = in_run & ~branch_taken & ~mc_start & lu;
    assign front_stall = mc_hold | lu_stall;

    // Reset forces every latch closed without waiting for a clock edge.
    assign ena_if  = reset & ~front_stall;
    assign ena_id  = reset & ~front_stall;
    assign ena_ex  = reset & ~mc_hold;
    assign ena_mem = reset;
    assign ena_wb  = reset;
    assign x_id    = reset & flush;
    assign x_ex    = reset & (flush | lu_stall);
    assign x_mem   = reset & mc_hold;

    assign stall_cnt  = stall_q;
    assign mc_timeout = timeout_q;
    assign busy       = ~in_run;

    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            wd_q      <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (front_stall && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);

            case (state_q)
                ST_RUN: begin
                    if (!branch_taken && mc_start) begin
                        state_q <= ST_MC_WAIT;
                        wd_q    <= '0;
                    end
                end
                ST_MC_WAIT: begin
                    if (mc_done) begin
                        state_q <= ST_MC_DRAIN;
                    end else if (wd_q == WD_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_RUN;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                ST_MC_DRAIN: state_q <= ST_RUN;
                default:     state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: per-cycle behavioural model compare plus directed literal checks.
module tb_pipeline_ctrl;

    localparam int MCMAX = 8;
    localparam int CW    = 4;
    localparam int SMAX  = (1 << CW) - 1;

    logic          stg_clk;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_use_rs1, id_use_rs2, ex_save_to_reg, ex_is_load;
    logic          mem_save_to_reg, wb_save_to_reg, branch_taken, mc_start, mc_done;
    logic          ena_if, ena_id, ena_ex, ena_mem, ena_wb, x_id, x_ex, x_mem;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;
    logic          mc_timeout, busy;

    int n_chk  = 0;
    int n_fail = 0;

    pipeline_ctrl #(.MC_MAX_CYCLES(MCMAX), .CNT_W(CW)) dut (
        .stg_clk(stg_clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_save_to_reg(ex_save_to_reg), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_save_to_reg(mem_save_to_reg),
        .wb_rd(wb_rd), .wb_save_to_reg(wb_save_to_reg),
        .branch_taken(branch_taken), .mc_start(mc_start), .mc_done(mc_done),
        .ena_if(ena_if), .ena_id(ena_id), .ena_ex(ena_ex), .ena_mem(ena_mem), .ena_wb(ena_wb),
        .x_id(x_id), .x_ex(x_ex), .x_mem(x_mem),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .mc_timeout(mc_timeout), .busy(busy)
    );

    initial stg_clk = 1'b0;
    always #5 stg_clk = ~stg_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (mem_save_to_reg && mem_rd != 0 && mem_rd == rs) return 2'd1;
        if (wb_save_to_reg && wb_rd != 0 && wb_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    // Model: mode 0 = normal flow, 1 = waiting on multi-cycle unit, 2 = drain.
    int m_mode = 0, m_wd = 0, m_stall = 0, m_to = 0;
    int n_mode = 0, n_wd = 0, n_stall = 0, n_to = 0;
    logic [4:0] e_en;
    logic [2:0] e_x;
    logic       m_lu;

    always @(negedge reset) begin
        m_mode = 0; m_wd = 0; m_stall = 0; m_to = 0;
        n_mode = 0; n_wd = 0; n_stall = 0; n_to = 0;
    end

    always @(negedge stg_clk) begin
        if (!reset) begin
            chk("rst_ena_x", {ena_if, ena_id, ena_ex, ena_mem, ena_wb, x_id, x_ex, x_mem}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_stall", stall_cnt, 0);
            chk("rst_timeout", mc_timeout, 0);
        end else begin
            n_mode = m_mode; n_wd = m_wd; n_stall = m_stall; n_to = m_to;
            m_lu = ex_is_load && ex_save_to_reg && ex_rd != 0 &&
                   ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            e_en = 5'b11111;
            e_x  = 3'b000;
            if (m_mode == 0) begin
                if (branch_taken) e_x = 3'b110;
                else if (mc_start) begin
                    e_en = 5'b00011; e_x = 3'b001; n_mode = 1; n_wd = 0;
                end else if (m_lu) begin
                    e_en = 5'b00111; e_x = 3'b010;
                end
            end else if (m_mode == 1) begin
                e_en = 5'b00011; e_x = 3'b001;
                if (mc_done) n_mode = 2;
                else if (m_wd == MCMAX - 1) begin n_to = 1; n_mode = 0; end
                else n_wd = m_wd + 1;
            end else begin
                n_mode = 0;
            end
            if (!e_en[4] && m_stall < SMAX) n_stall = m_stall + 1;
            chk("model_ena", {ena_if, ena_id, ena_ex, ena_mem, ena_wb}, e_en);
            chk("model_x", {x_id, x_ex, x_mem}, e_x);
            chk("model_fwd", {fwd_a, fwd_b}, {fwd_exp(ex_rs1), fwd_exp(ex_rs2)});
            chk("model_busy", busy, (m_mode != 0));
            chk("model_stall", stall_cnt, m_stall);
            chk("model_timeout", mc_timeout, m_to);
        end
    end

    always @(posedge stg_clk) begin
        if (reset) begin
            m_mode = n_mode; m_wd = n_wd; m_stall = n_stall; m_to = n_to;
        end
    end

    task automatic tick();
        @(posedge stg_clk);
        #1;
    endtask

    task automatic clr_in();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_save_to_reg = 0; ex_is_load = 0;
        mem_rd = 0; mem_save_to_reg = 0; wb_rd = 0; wb_save_to_reg = 0;
        branch_taken = 0; mc_start = 0; mc_done = 0;
    endtask

    task automatic set_lu();
        ex_is_load = 1; ex_save_to_reg = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    endtask

    int busy_n, xm_n, first_to;

    initial begin
        reset = 1'b0;
        clr_in();
        repeat (3) tick();
        chk("reset_ena_if", ena_if, 0);
        chk("reset_stall", stall_cnt, 0);
        reset = 1'b1;
        #1;
        chk("first_cycle_ena_if", ena_if, 1);
        chk("first_cycle_busy", busy, 0);

        // Forwarding priority and rd=0
        tick();
        mem_rd = 5; wb_rd = 5; mem_save_to_reg = 1; wb_save_to_reg = 1; ex_rs1 = 5;
        #1 chk("fwd_mem_prio", fwd_a, 2'b01);
        mem_save_to_reg = 0;
        #1 chk("fwd_wb", fwd_a, 2'b10);
        tick();
        mem_save_to_reg = 1; mem_rd = 0; ex_rs2 = 0; wb_rd = 3;
        #1 chk("fwd_rd0_b", fwd_b, 2'b00);
        chk("fwd_none_a", fwd_a, 2'b00);
        tick();
        clr_in();

        // Load-use stall
        set_lu();
        #1 chk("lu_front", {ena_if, ena_id}, 2'b00);
        chk("lu_xex", {ena_ex, x_ex}, 2'b11);
        tick();
        clr_in();
        #1 chk("lu_after_ena_if", ena_if, 1);
        chk("lu_stall_cnt", stall_cnt, 1);

        // rd=0 never stalls
        tick();
        ex_is_load = 1; ex_save_to_reg = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        #1 chk("rd0_no_stall", ena_if, 1);
        tick();
        clr_in();

        // Branch outranks load-use and mc_start
        set_lu();
        branch_taken = 1; mc_start = 1;
        #1 chk("br_x", {x_id, x_ex, x_mem}, 3'b110);
        chk("br_ena", {ena_if, ena_id, ena_ex, ena_mem, ena_wb}, 5'b11111);
        tick();
        clr_in();
        #1 chk("br_stall_same", stall_cnt, 1);
        chk("br_busy", busy, 0);

        // Multi-cycle op, done after 4 wait cycles
        busy_n = 0; xm_n = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            mc_start = (c == 0);
            mc_done  = (c == 4);
            #1;
            busy_n += int'(busy);
            xm_n   += int'(x_mem);
            if (c == 5) chk("mc_drain_ena", {ena_if, ena_id, ena_ex, ena_mem, ena_wb, x_mem}, 6'b111110);
        end
        chk("mc_busy_cycles", busy_n, 5);
        chk("mc_xmem_cycles", xm_n, 5);
        chk("mc_stall_cnt", stall_cnt, 6);

        // Watchdog, no completion
        busy_n = 0; first_to = -1;
        clr_in();
        for (int c = 0; c < 12; c++) begin
            tick();
            mc_start = (c == 0);
            #1;
            busy_n += int'(busy);
            if (mc_timeout && first_to < 0) first_to = c;
        end
        chk("wd_busy_cycles", busy_n, 8);
        chk("wd_first_cycle", first_to, 9);
        chk("wd_flag", mc_timeout, 1);
        chk("wd_back_run", busy, 0);
        chk("wd_stall_sat", stall_cnt, 15);

        // Saturation holds, flag sticky
        tick();
        set_lu();
        tick();
        clr_in();
        #1 chk("sat_stall", stall_cnt, 15);
        chk("sticky_timeout", mc_timeout, 1);

        // mc_done coincident with mc_start is ignored
        busy_n = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            mc_start = (c == 0);
            mc_done  = (c == 0) || (c == 2);
            #1;
            busy_n += int'(busy);
        end
        chk("mc_done_ignored_busy", busy_n, 3);
        clr_in();

        // Asynchronous reset mid-wait
        tick();
        mc_start = 1;
        tick();
        mc_start = 0;
        tick();
        chk("pre_reset_busy", busy, 1);
        #1 reset = 1'b0;
        #1;
        chk("areset_ena", {ena_if, ena_id, ena_ex, ena_mem, ena_wb}, 5'b00000);
        chk("areset_busy", busy, 0);
        chk("areset_stall", stall_cnt, 0);
        chk("areset_timeout", mc_timeout, 0);
        tick();
        tick();
        reset = 1'b1;
        #1 chk("post_reset_run", {busy, ena_if}, 2'b01);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
